// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: program-memory address/data, decoder handshake and redirect inputs.
// FETCH_PERF_COUNT_EN adds the fetch_count / flush_count performance outputs.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] program_data_address;
   logic [DATA_W-1:0] program_data;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              branch_valid;
   logic              branch_cond;
   logic [ADDR_W-1:0] branch_target;
   logic              alu_overflow;
   logic              halt;
   logic              branch_taken;
`ifdef FETCH_PERF_COUNT_EN
   logic [15:0]       fetch_count;
   logic [15:0]       flush_count;
`endif

   // instr is transferred on any rising edge where instr_valid and instr_ready are both high;
   // instr_valid never drops without a transfer except on a taken redirect (squash) or reset.
   modport slave (
`ifdef FETCH_PERF_COUNT_EN
      output fetch_count,
      output flush_count,
`endif
      output program_data_address,
      input  program_data,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready,
      input  branch_valid,
      input  branch_cond,
      input  branch_target,
      input  alu_overflow,
      input  halt,
      output branch_taken
   );

   modport master (
`ifdef FETCH_PERF_COUNT_EN
      input  fetch_count,
      input  flush_count,
`endif
      input  program_data_address,
      output program_data,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready,
      output branch_valid,
      output branch_cond,
      output branch_target,
      output alu_overflow,
      output halt,
      input  branch_taken
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch sequencer feeding a decoder over valid/ready, with JUMP/JUMP_OV redirects.
// Optional macro FETCH_PERF_COUNT_EN enables saturating fetch/flush counters.
module instruction_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   instruction_fetch_unit_if.slave   bus,
   output logic [1:0]                o_dbg_state
);
   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;
   logic              r_branch_taken;

   logic w_take;
   logic w_accept;

   assign w_take   = bus.branch_valid & (~bus.branch_cond | bus.alu_overflow);
   assign w_accept = r_instr_valid & bus.instr_ready;

   // The memory address is the pc register itself so redirect inputs never reach it combinationally.
   assign bus.program_data_address = r_pc;
   assign bus.instr                = r_instr;
   assign bus.instr_pc             = r_instr_pc;
   assign bus.instr_valid          = r_instr_valid;
   assign bus.branch_taken         = r_branch_taken;
   assign o_dbg_state              = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_FILL;
         r_pc           <= RESET_PC;
         r_instr        <= '0;
         r_instr_pc     <= '0;
         r_instr_valid  <= 1'b0;
         r_branch_taken <= 1'b0;
      end else begin
         r_branch_taken <= 1'b0;
         case (r_state)
            // Memory has not yet sampled RESET_PC, so nothing is captured here.
            ST_FILL: begin
               r_state <= ST_RUN;
               if (w_take) begin
                  r_pc           <= bus.branch_target;
                  r_branch_taken <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_take) begin
                  r_pc           <= bus.branch_target;
                  r_instr_valid  <= 1'b0;
                  r_branch_taken <= 1'b1;
               end else if (bus.halt) begin
                  r_state <= ST_HALTED;
                  if (w_accept) r_instr_valid <= 1'b0;
               end else if (~r_instr_valid | bus.instr_ready) begin
                  r_instr       <= bus.program_data;
                  r_instr_pc    <= r_pc;
                  r_pc          <= r_pc + ADDR_W'(1);
                  r_instr_valid <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (w_take) begin
                  r_pc           <= bus.branch_target;
                  r_instr_valid  <= 1'b0;
                  r_branch_taken <= 1'b1;
               end else begin
                  if (w_accept) r_instr_valid <= 1'b0;
                  if (!bus.halt) r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [15:0] r_fetch_count;
   logic [15:0] r_flush_count;

   // A redirect is applied in every state whenever take is high, so take alone drives flush_count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_accept && (r_fetch_count != 16'hFFFF)) r_fetch_count <= r_fetch_count + 16'd1;
         if (w_take && (r_flush_count != 16'hFFFF))   r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign bus.fetch_count = r_fetch_count;
   assign bus.flush_count = r_flush_count;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: program-memory model, redirect/stall/halt/wrap/reset vectors,
// and a scoreboard that checks every accepted instruction against an expected queue.
module tb_instruction_fetch_unit;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   logic [DATA_W-1:0]        mem [256];
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   int total = 0;
   int bad   = 0;

   instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'd0)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // Program memory reads on the falling edge.
   always @(negedge clk) bus.program_data <= mem[bus.program_data_address];

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_instr_pc(input logic [ADDR_W-1:0] target);
      int n;
      n = 0;
      while (!(bus.instr_valid && bus.instr_pc == target) && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) check("wait_instr_pc_timeout", 32'(bus.instr_pc), 32'(target));
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int p = lo; p <= hi; p++) exp_q.push_back({8'(p), mem[p]});
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [ADDR_W+DATA_W-1:0] e;
      if (!reset && bus.instr_valid && bus.instr_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_accept", 32'(bus.instr_pc), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("accept_pc", 32'(bus.instr_pc), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            check("accept_instr", 32'(bus.instr), 32'(e[DATA_W-1:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i)};
      mem[0] = 16'h0000;  // NOP
      mem[1] = 16'h1001;  // LOAD(1)
      mem[2] = 16'h2000;  // SAVE_CU(0)
      mem[3] = 16'h1002;  // LOAD(2)

      // Accepted stream: 0..12, JUMP to 16..28, JUMP_OV to 50..255, wrap 0..5 (6 stays stalled).
      push_range(0, 12);
      push_range(16, 28);
      push_range(50, 255);
      push_range(0, 5);

      reset             = 1'b0;
      bus.instr_ready   = 1'b1;
      bus.branch_valid  = 1'b0;
      bus.branch_cond   = 1'b0;
      bus.branch_target = '0;
      bus.alu_overflow  = 1'b0;
      bus.halt          = 1'b0;
      #2 reset = 1'b1;
      step();
      step();
      check("rst_pc", 32'(bus.program_data_address), 32'h0);
      check("rst_instr", 32'(bus.instr), 32'h0);
      check("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
      check("rst_valid", 32'(bus.instr_valid), 32'h0);
      check("rst_taken", 32'(bus.branch_taken), 32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
`ifdef FETCH_PERF_COUNT_EN
      check("rst_fetch_count", 32'(bus.fetch_count), 32'h0);
      check("rst_flush_count", 32'(bus.flush_count), 32'h0);
`endif

      // Release: FILL cycle, then first instruction two edges after release.
      reset = 1'b0;
      step();
      check("fill_valid", 32'(bus.instr_valid), 32'h0);
      check("fill_to_run", 32'(dbg_state), 32'h1);
      step();
      check("first_valid", 32'(bus.instr_valid), 32'h1);
      check("first_pc", 32'(bus.instr_pc), 32'h0);
      check("first_instr", 32'(bus.instr), 32'h0000);
      step();
      check("second_pc", 32'(bus.instr_pc), 32'h1);
      check("second_instr", 32'(bus.instr), 32'h1001);

      // Stall three cycles on instr_pc = 5.
      wait_instr_pc(8'd5);
      bus.instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_instr_pc", 32'(bus.instr_pc), 32'h5);
         check("stall_pc", 32'(bus.program_data_address), 32'h6);
         check("stall_valid", 32'(bus.instr_valid), 32'h1);
      end
      bus.instr_ready = 1'b1;
      step();
      check("after_stall_pc", 32'(bus.instr_pc), 32'h6);

      // JUMP to 16 at instr_pc = 12.
      wait_instr_pc(8'd12);
      bus.branch_valid  = 1'b1;
      bus.branch_cond   = 1'b0;
      bus.branch_target = 8'd16;
      step();
      bus.branch_valid = 1'b0;
      check("jump_taken", 32'(bus.branch_taken), 32'h1);
      check("jump_bubble", 32'(bus.instr_valid), 32'h0);
      check("jump_pc", 32'(bus.program_data_address), 32'd16);
      step();
      check("jump_taken_pulse_end", 32'(bus.branch_taken), 32'h0);
      check("jump_target_pc", 32'(bus.instr_pc), 32'd16);
      check("jump_target_instr", 32'(bus.instr), 32'h4A10);

      // JUMP_OV without overflow is ignored.
      wait_instr_pc(8'd26);
      bus.branch_valid  = 1'b1;
      bus.branch_cond   = 1'b1;
      bus.branch_target = 8'd50;
      bus.alu_overflow  = 1'b0;
      step();
      bus.branch_valid = 1'b0;
      check("jov_ignored_taken", 32'(bus.branch_taken), 32'h0);
      check("jov_ignored_pc", 32'(bus.instr_pc), 32'd27);
      step();
      check("jov_ignored_next", 32'(bus.instr_pc), 32'd28);
      // JUMP_OV with overflow redirects.
      bus.branch_valid = 1'b1;
      bus.alu_overflow = 1'b1;
      step();
      bus.branch_valid = 1'b0;
      bus.alu_overflow = 1'b0;
      check("jov_taken", 32'(bus.branch_taken), 32'h1);
      check("jov_bubble", 32'(bus.instr_valid), 32'h0);
      step();
      check("jov_target_pc", 32'(bus.instr_pc), 32'd50);
      check("jov_target_instr", 32'(bus.instr), 32'h6832);

      // Wrap 255 -> 0.
      wait_instr_pc(8'd255);
      step();
      check("wrap_pc", 32'(bus.instr_pc), 32'h0);
      check("wrap_valid", 32'(bus.instr_valid), 32'h1);

      // Halt four cycles at instr_pc = 2; instr 2 drains, pc frozen at 3.
      wait_instr_pc(8'd2);
      bus.halt = 1'b1;
      step();
      check("halt_state", 32'(dbg_state), 32'h2);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         check("halt_pc_frozen", 32'(bus.program_data_address), 32'h3);
         check("halt_no_instr", 32'(bus.instr_valid), 32'h0);
      end
      bus.halt = 1'b0;
      step();
      check("unhalt_state", 32'(dbg_state), 32'h1);
      check("unhalt_bubble", 32'(bus.instr_valid), 32'h0);
      step();
      check("resume_pc", 32'(bus.instr_pc), 32'h3);
      check("resume_instr", 32'(bus.instr), 32'h1002);

      // Stall on instr_pc = 6, then reset asynchronously between edges.
      wait_instr_pc(8'd6);
      bus.instr_ready = 1'b0;
      step();
      step();
      check("pre_reset_valid", 32'(bus.instr_valid), 32'h1);
      check("pre_reset_pc", 32'(bus.program_data_address), 32'h7);
`ifdef FETCH_PERF_COUNT_EN
      check("fetch_count", 32'(bus.fetch_count), 32'd238);
      check("flush_count", 32'(bus.flush_count), 32'd2);
`endif
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.instr_valid), 32'h0);
      check("async_rst_pc", 32'(bus.program_data_address), 32'h0);
      check("async_rst_instr_pc", 32'(bus.instr_pc), 32'h0);
      check("async_rst_instr", 32'(bus.instr), 32'h0);
      check("async_rst_state", 32'(dbg_state), 32'h0);
`ifdef FETCH_PERF_COUNT_EN
      check("async_rst_fetch_count", 32'(bus.fetch_count), 32'h0);
      check("async_rst_flush_count", 32'(bus.flush_count), 32'h0);
`endif
      step();
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
